// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the uPower fetch sequencer.
//   INSTR_W    : instruction word width
//   fs_state_e : fetch FSM state encoding (IDLE=0, FETCH=1, DONE=2)
package fetch_sequencer_pkg;

  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_FETCH = 2'd1,
    FS_DONE  = 2'd2
  } fs_state_e;

endpackage

// File: rtl/fetch_sequencer_stage_reg.sv
// One-entry valid/ready output register between fetch and decode.
//
// Handshake: a word moves to decode on any cycle where valid_o & ready_i.
// While valid_o is high and ready_i is low, instr_o/pc_o do not change.
//
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   load_i     : capture data_i/pc_i this edge (only raised when the slot is
//                free or draining this cycle)
//   flush_i    : drop the held word (it still counts as a transfer if it
//                was accepted in this same cycle)
//   ready_i    : decode accepts
//   data_i     : instruction word to capture
//   pc_i       : word index of data_i
//   valid_o    : slot holds a word
//   instr_o    : held instruction
//   pc_o       : word index of instr_o
//   xfer_o     : handshake completed this cycle
module fetch_stage_reg
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               flush_i,
  input  logic               ready_i,
  input  logic [INSTR_W-1:0] data_i,
  input  logic [ADDR_W-1:0]  pc_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               xfer_o
);

  logic               valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  pc_q;

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign xfer_o  = valid_q & ready_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (flush_i) begin
      // Data/pc keep their old values; only validity is withdrawn.
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= data_i;
      pc_q    <= pc_i;
    end else if (xfer_o) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter and fetch FSM for the uPower core.
//
// Drives a combinational, word-indexed instruction memory (imem_addr = pc),
// registers each fetched word into a one-entry stage towards decode, accepts
// branch redirects from execute, and stops once pc runs past NUM_INSTR.
//
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   start          : level, only looked at in IDLE
//   imem_addr      : word index to instruction memory (= pc)
//   imem_data      : instruction at imem_addr, same cycle
//   if_valid/if_ready/if_instr/if_pc : valid/ready output stage to decode
//   branch_taken   : one-cycle redirect pulse, branch_target is the word index
//   done           : DONE state with the output stage drained
//   fetch_count    : number of handshakes with decode (wraps)
//   dbg_state      : current FSM state
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int NUM_INSTR = 8,
  parameter int START_PC  = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               done,
  output logic [31:0]        fetch_count,
  output fs_state_e          dbg_state
);

  localparam logic [ADDR_W-1:0] LIMIT   = ADDR_W'(NUM_INSTR);
  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(START_PC);

  fs_state_e         state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       count_q;

  logic [ADDR_W-1:0] pc_inc_d;
  logic [31:0]       count_d;
  logic              pc_in_range;
  logic              tgt_in_range;
  logic              load;
  logic              flush;
  logic              xfer;

  assign pc_inc_d     = pc_q + ADDR_W'(1);
  assign count_d      = count_q + 32'd1;
  assign pc_in_range  = (pc_q < LIMIT);
  assign tgt_in_range = (branch_target < LIMIT);

  // A redirect in FETCH always wins over a load; the slot may also be
  // refilled in the same cycle it drains.
  assign load  = (state_q == FS_FETCH) && !branch_taken && pc_in_range &&
                 (!if_valid || if_ready);
  // Out-of-range redirects in DONE are ignored, so nothing is flushed then.
  assign flush = branch_taken &&
                 ((state_q == FS_FETCH) || ((state_q == FS_DONE) && tgt_in_range));

  fetch_stage_reg #(.ADDR_W(ADDR_W)) u_stage (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load),
    .flush_i (flush),
    .ready_i (if_ready),
    .data_i  (imem_data),
    .pc_i    (pc_q),
    .valid_o (if_valid),
    .instr_o (if_instr),
    .pc_o    (if_pc),
    .xfer_o  (xfer)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FS_IDLE;
      pc_q    <= PC_INIT;
      count_q <= '0;
    end else begin
      if (xfer) count_q <= count_d;
      case (state_q)
        FS_IDLE: begin
          if (start) begin
            state_q <= FS_FETCH;
            pc_q    <= PC_INIT;
          end
        end
        FS_FETCH: begin
          if (branch_taken) begin
            pc_q <= branch_target;
            if (!tgt_in_range) state_q <= FS_DONE;
          end else if (!pc_in_range) begin
            // Entered FETCH already past the program (e.g. START_PC too big).
            state_q <= FS_DONE;
          end else if (load) begin
            pc_q <= pc_inc_d;
            if (pc_inc_d == LIMIT) state_q <= FS_DONE;
          end
        end
        FS_DONE: begin
          if (branch_taken && tgt_in_range) begin
            pc_q    <= branch_target;
            state_q <= FS_FETCH;
          end
        end
        default: state_q <= FS_IDLE;
      endcase
    end
  end

  assign imem_addr   = pc_q;
  assign fetch_count = count_q;
  assign done        = (state_q == FS_DONE) && !if_valid;
  assign dbg_state   = state_q;

endmodule
